// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill count, threshold flags, sticky error
// flags, synchronous flush, write pass-through when full and optional FWFT reads.
module sync_fifo_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int GAP   = 2,
  parameter int FWFT  = 0,
  localparam int AW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [AW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             half,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW-1:0] DEPTH_LVL = AW'(DEPTH);
  localparam logic [AW-1:0] AF_LVL    = AW'(DEPTH - GAP);
  localparam logic [AW-1:0] AE_LVL    = AW'(GAP);
  localparam logic [AW-1:0] HALF_LVL  = AW'(DEPTH / 2);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  logic             empty_s, full_s;
  logic             rd_acc_s, wr_acc_s;
  logic [WIDTH-1:0] head_s;

  assign empty_s  = (count_q == {AW{1'b0}});
  assign full_s   = (count_q == DEPTH_LVL);
  assign rd_acc_s = rd_en && !empty_s;
  // A full FIFO still takes a write when the same cycle frees a slot.
  assign wr_acc_s = wr_en && (!full_s || rd_acc_s);
  assign head_s   = mem_q[rd_ptr_q[AW-2:0]];

  // Next-state computation for pointers, count, error flags and read register
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (clr) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {AW{1'b0}};
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_acc_s) begin
        rd_ptr_d   = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        rd_data_d  = head_s;
        rd_valid_d = 1'b1;
      end else begin
        rd_ptr_d   = rd_ptr_q;
      end
      count_d = count_q + {{(AW-1){1'b0}}, wr_acc_s} - {{(AW-1){1'b0}}, rd_acc_s};
      if (wr_en && !wr_acc_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
      if (rd_en && empty_s) begin
        unf_d = 1'b1;
      end else begin
        unf_d = unf_q;
      end
    end
  end

  // Control state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {AW{1'b0}};
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rd_data_q  <= {WIDTH{1'b0}};
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage array write port; contents survive reset and flush
  always_ff @(posedge clk) begin
    if (!clr && wr_acc_s) begin
      mem_q[wr_ptr_q[AW-2:0]] <= wr_data;
    end
  end

  assign count        = count_q;
  assign empty        = empty_s;
  assign full         = full_s;
  assign almost_full  = (count_q >= AF_LVL) && !full_s;
  assign almost_empty = (count_q <= AE_LVL) && !empty_s;
  assign half         = (count_q >= HALF_LVL);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // FWFT presents the head word directly; it is forced to zero while empty.
  assign rd_data  = (FWFT != 0) ? (empty_s ? {WIDTH{1'b0}} : head_s) : rd_data_q;
  assign rd_valid = (FWFT != 0) ? !empty_s : rd_valid_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised bench for sync_fifo_param: one registered-read and one FWFT instance
// share stimulus and are compared against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int GAP   = 2;
  localparam int AW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clr = 1'b0;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = 8'h00;
  logic             rd_en = 1'b0;

  logic [WIDTH-1:0] rd_data0, rd_data1;
  logic             rd_valid0, rd_valid1;
  logic [AW-1:0]    count0, count1;
  logic             full0, empty0, af0, ae0, half0, ovf0, unf0;
  logic             full1, empty1, af1, ae1, half1, ovf1, unf1;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_rd;
  bit               m_rv, m_ovf, m_unf;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GAP(GAP), .FWFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .count(count0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .half(half0), .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GAP(GAP), .FWFT(1)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .count(count1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .half(half1), .overflow(ovf1), .underflow(unf1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rd  = 8'h00;
    m_rv  = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic check_all();
    int n;
    n = m_q.size();
    check("count0", 32'(count0), 32'(n));
    check("count1", 32'(count1), 32'(n));
    check("empty",  {31'd0, empty0}, {31'd0, n == 0});
    check("full",   {31'd0, full0},  {31'd0, n == DEPTH});
    check("afull",  {31'd0, af0},    {31'd0, (n >= DEPTH - GAP) && (n != DEPTH)});
    check("aempty", {31'd0, ae0},    {31'd0, (n <= GAP) && (n != 0)});
    check("half",   {31'd0, half0},  {31'd0, n >= DEPTH / 2});
    check("ovf",    {31'd0, ovf0},   {31'd0, m_ovf});
    check("unf",    {31'd0, unf0},   {31'd0, m_unf});
    check("flags1", {27'd0, empty1, full1, af1, ae1, half1},
                    {27'd0, empty0, full0, af0, ae0, half0});
    check("err1",   {30'd0, ovf1, unf1}, {30'd0, m_ovf, m_unf});
    check("rdata0", 32'(rd_data0),  32'(m_rd));
    check("rvalid0", {31'd0, rd_valid0}, {31'd0, m_rv});
    check("rvalid1", {31'd0, rd_valid1}, {31'd0, n != 0});
    if (n != 0) begin
      check("rdata1", 32'(rd_data1), 32'(m_q[0]));
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, check outputs.
  task automatic cycle(input bit we, input logic [WIDTH-1:0] wd, input bit re, input bit cl);
    bit emp, ful, racc, wacc;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    clr     = cl;
    @(posedge clk);
    emp = (m_q.size() == 0);
    ful = (m_q.size() == DEPTH);
    if (cl) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rv  = 1'b0;
    end else begin
      racc = re && !emp;
      wacc = we && (!ful || racc);
      if (re && emp) m_unf = 1'b1;
      if (we && !wacc) m_ovf = 1'b1;
      m_rv = racc;
      if (racc) m_rd = m_q.pop_front();
      if (wacc) m_q.push_back(wd);
    end
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr   = 1'b0;
    check_all();
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    #11 rst = 1'b1;

    // Fill 0x01..0x08, flags checked at every level
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    // Drain in order, then an idle cycle to see rd_valid drop
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Overflow, flush, underflow
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    // Write into empty with rd_en: write taken, read rejected
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 8'h3C, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Full pass-through across pointer wraps
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // FWFT presentation without rd_en, then pop
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomised traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) < 55), 8'($urandom),
            ($urandom_range(0, 99) < 45), ($urandom_range(0, 59) == 0));
    end

    // Asynchronous reset with five entries held
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    rst = 1'b0;
    #2;
    model_reset();
    check_all();
    #2 rst = 1'b1;
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
